id_issue_ctrl: RTL and testbench

ID_ISSUE_CTRL -- requirements
Module: id_issue_ctrl

---
 rtl/id_issue_ctrl_if.sv | 33 +++
 rtl/id_issue_ctrl.sv | 125 ++++++++++++
 tb/tb_id_issue_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_issue_ctrl_if.sv
// Issue-stage bus: fetch handshake, EX handshake with decoded fields,
// writeback notification, flush and status outputs.
// The slave modport is the issue controller; the master modport is its environment.
interface id_issue_ctrl_if #(
    parameter int STALL_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        instr;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_opcode;
    logic [1:0]         out_rs1;
    logic [1:0]         out_rs2;
    logic [1:0]         out_rd;
    logic               wb_valid;
    logic [1:0]         wb_rd;
    logic               flush;
    logic               halted;
    logic [STALL_W-1:0] stall_cnt;

    modport master (
        output in_valid, instr, out_ready, wb_valid, wb_rd, flush,
        input  in_ready, out_valid, out_opcode, out_rs1, out_rs2, out_rd,
               halted, stall_cnt
    );

    modport slave (
        input  in_valid, instr, out_ready, wb_valid, wb_rd, flush,
        output in_ready, out_valid, out_opcode, out_rs1, out_rs2, out_rd,
               halted, stall_cnt
    );
endinterface

// File: rtl/id_issue_ctrl.sv
// Decode/issue controller: one-entry instruction buffer, 4-bit register
// scoreboard for RAW/WAW hazard stalls, HALT latch and saturating stall counter.
module id_issue_ctrl #(
    parameter int STALL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    id_issue_ctrl_if.slave     bus
);
    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [9:0]         r_instr;     // instr[15:6]; low bits carry no fields
    logic [3:0]         r_sb;
    logic [3:0]         w_sb_nxt;
    logic [STALL_W-1:0] r_stall_cnt;

    logic [3:0] w_opcode;
    logic [1:0] w_rs1;
    logic [1:0] w_rs2;
    logic [1:0] w_rd;
    logic       w_reads_rs1;
    logic       w_reads_rs2;
    logic       w_writes_rd;
    logic       w_buf_valid;
    logic       w_halted;
    logic       w_hazard;
    logic       w_out_valid;
    logic       w_issue;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_unused_low;

    assign w_opcode     = r_instr[9:6];
    assign w_rs1        = r_instr[5:4];
    assign w_rs2        = r_instr[3:2];
    assign w_rd         = r_instr[1:0];
    assign w_unused_low = ^bus.instr[5:0];

    assign w_buf_valid = (r_state == ST_HOLD);
    assign w_halted    = (r_state == ST_HALTED);

    // Classify the held opcode into which registers it reads and whether it writes rd.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_reads_rs1 = 1'b0;
        w_reads_rs2 = 1'b0;
        w_writes_rd = 1'b0;
        if (w_opcode >= 4'h1 && w_opcode <= 4'h7) begin
            w_reads_rs1 = 1'b1;
            w_reads_rs2 = 1'b1;
            w_writes_rd = 1'b1;
        end else if (w_opcode == 4'h8) begin
            w_reads_rs1 = 1'b1;
            w_writes_rd = 1'b1;
        end else if (w_opcode >= 4'h9 && w_opcode <= 4'hE) begin
            w_reads_rs1 = 1'b1;
            w_reads_rs2 = 1'b1;
        end
    end

    // Hazard looks only at the registered scoreboard: a writeback this cycle is not bypassed.
    assign w_hazard = w_buf_valid & ((w_reads_rs1 & r_sb[w_rs1]) |
                                     (w_reads_rs2 & r_sb[w_rs2]) |
                                     (w_writes_rd & r_sb[w_rd]));

    assign w_out_valid = ~rst & w_buf_valid & ~w_hazard & ~w_halted;
    assign w_issue     = w_out_valid & bus.out_ready;
    assign w_in_ready  = ~rst & ~w_halted & ~bus.flush & (~w_buf_valid | w_issue);
    assign w_accept    = bus.in_valid & w_in_ready;

    // Next buffer state; an issued HALT wins over a coincident flush or accept.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_issue && w_opcode == 4'hF) w_state_nxt = ST_HALTED;
                else if (bus.flush)              w_state_nxt = ST_EMPTY;
                else if (w_accept)               w_state_nxt = ST_HOLD;
                else if (w_issue)                w_state_nxt = ST_EMPTY;
            end
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_EMPTY;
        endcase
    end

    // Scoreboard update: clear on writeback, then set on issue so a same-bit set wins.
    always_comb begin
        w_sb_nxt = r_sb;
        if (bus.wb_valid)           w_sb_nxt[bus.wb_rd] = 1'b0;
        if (w_issue && w_writes_rd) w_sb_nxt[w_rd]      = 1'b1;
    end

    // Register state, buffer, scoreboard and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data buffer is reset too, because the out_* fields must read 0 after reset.
            r_state     <= ST_EMPTY;
            r_instr     <= '0;
            r_sb        <= '0;
            r_stall_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            r_sb    <= w_sb_nxt;
            if (w_accept) r_instr <= bus.instr[15:6];
            if (w_hazard && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_opcode = w_opcode;
    assign bus.out_rs1    = w_rs1;
    assign bus.out_rs2    = w_rs2;
    assign bus.out_rd     = w_rd;
    assign bus.halted     = w_halted & ~rst;
    assign bus.stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Self-checking bench for id_issue_ctrl: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the issue stage.
module tb_id_issue_ctrl;
    localparam int STALL_W   = 8;
    localparam int STALL_MAX = (1 << STALL_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_issue_ctrl_if #(.STALL_W(STALL_W)) bus ();
    id_issue_ctrl #(.STALL_W(STALL_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model state
    bit          m_valid;
    bit          m_halted;
    logic [15:0] m_instr;
    bit          m_sb [4];
    int          m_stall;
    int          n_issued;

    // Values sampled from the DUT in the last cycle() call
    logic       s_in_ready, s_out_valid, s_halted;
    logic [7:0] s_stall;
    logic [9:0] s_fields;

    function automatic void op_class(input logic [3:0] op, output bit r1, output bit r2, output bit w);
        r1 = 0; r2 = 0; w = 0;
        if (op >= 1 && op <= 7) begin r1 = 1; r2 = 1; w = 1; end
        else if (op == 8)       begin r1 = 1; w = 1; end
        else if (op >= 9 && op <= 14) begin r1 = 1; r2 = 1; end
    endfunction

    task automatic set_idle();
        bus.in_valid  = 0;
        bus.instr     = 16'h0000;
        bus.out_ready = 1;
        bus.wb_valid  = 0;
        bus.wb_rd     = 2'd0;
        bus.flush     = 0;
    endtask

    function automatic void model_reset();
        m_valid = 0; m_halted = 0; m_instr = 16'h0; m_stall = 0;
        for (int i = 0; i < 4; i++) m_sb[i] = 0;
    endfunction

    // One clock: called just after a negedge with inputs applied; compares, then advances model.
    task automatic cycle();
        bit r1, r2, w, haz, exp_ov, exp_ir, issue, accept, exp_halt;
        logic [3:0] op;
        op = m_instr[15:12];
        op_class(op, r1, r2, w);
        haz = m_valid && ((r1 && m_sb[m_instr[11:10]]) || (r2 && m_sb[m_instr[9:8]]) ||
                          (w && m_sb[m_instr[7:6]]));
        exp_ov   = !rst && m_valid && !haz && !m_halted;
        issue    = exp_ov && bus.out_ready;
        exp_ir   = !rst && !m_halted && !bus.flush && (!m_valid || issue);
        accept   = bus.in_valid && exp_ir;
        exp_halt = !rst && m_halted;
        #1;
        s_in_ready  = bus.in_ready;
        s_out_valid = bus.out_valid;
        s_halted    = bus.halted;
        s_stall     = bus.stall_cnt;
        s_fields    = {bus.out_opcode, bus.out_rs1, bus.out_rs2, bus.out_rd};
        n_checks += 5;
        if (s_in_ready !== exp_ir) begin
            n_fails++; $display("FAIL model_in_ready t=%0t got %b expected %b", $time, s_in_ready, exp_ir);
        end
        if (s_out_valid !== exp_ov) begin
            n_fails++; $display("FAIL model_out_valid t=%0t got %b expected %b", $time, s_out_valid, exp_ov);
        end
        if (s_halted !== exp_halt) begin
            n_fails++; $display("FAIL model_halted t=%0t got %b expected %b", $time, s_halted, exp_halt);
        end
        if (s_stall !== 8'(m_stall)) begin
            n_fails++; $display("FAIL model_stall_cnt t=%0t got %0d expected %0d", $time, s_stall, m_stall);
        end
        if (s_fields !== m_instr[15:6]) begin
            n_fails++; $display("FAIL model_fields t=%0t got %h expected %h", $time, s_fields, m_instr[15:6]);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (haz && m_stall < STALL_MAX) m_stall++;
            if (bus.wb_valid) m_sb[bus.wb_rd] = 0;
            if (issue) begin
                n_issued++;
                if (w) m_sb[m_instr[7:6]] = 1;
            end
            if (accept) m_instr = bus.instr;
            if (issue && op == 4'hF)  begin m_halted = 1; m_valid = 0; end
            else if (bus.flush)       m_valid = 0;
            else if (accept)          m_valid = 1;
            else if (issue)           m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        // Build a held, stalled state first so reset has something to clear.
        set_idle();
        bus.in_valid = 1; bus.instr = 16'h1040; cycle();
        bus.instr = 16'h1400; cycle();
        bus.in_valid = 0; cycle(); cycle(); cycle();
        rst = 1; bus.in_valid = 1; bus.instr = 16'h2000;
        cycle();
        n_checks += 2;
        if (s_in_ready !== 1'b0) begin n_fails++; $display("FAIL reset_in_ready got %b expected 0", s_in_ready); end
        if (s_out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid got %b expected 0", s_out_valid); end
        rst = 0; bus.in_valid = 0;
        cycle();
        n_checks += 4;
        if (s_stall !== 8'd0)      begin n_fails++; $display("FAIL reset_stall got %0d expected 0", s_stall); end
        if (s_halted !== 1'b0)     begin n_fails++; $display("FAIL reset_halted got %b expected 0", s_halted); end
        if (s_fields !== 10'h000)  begin n_fails++; $display("FAIL reset_fields got %h expected 000", s_fields); end
        if (s_in_ready !== 1'b1)   begin n_fails++; $display("FAIL reset_in_ready_after got %b expected 1", s_in_ready); end
    endtask

    task automatic test_stream();
        int base;
        logic [1:0] rds [16];
        do_reset();
        base = n_issued;
        for (int c = 0; c < 13; c++) begin
            set_idle();
            rds[c] = (c % 2) ? 2'd3 : 2'd0;
            if (c < 12) begin
                bus.in_valid = 1;
                bus.instr = {4'(1 + c % 7), 2'd1, 2'd2, rds[c], 6'd0};
            end
            if (c >= 2) begin bus.wb_valid = 1; bus.wb_rd = rds[c-2]; end
            cycle();
            if (c >= 1) begin
                n_checks++;
                if (s_out_valid !== 1'b1) begin n_fails++; $display("FAIL stream_out_valid c=%0d got %b expected 1", c, s_out_valid); end
            end
        end
        n_checks += 2;
        if (n_issued - base !== 12) begin n_fails++; $display("FAIL stream_issues got %0d expected 12", n_issued - base); end
        if (bus.stall_cnt !== 8'd0) begin n_fails++; $display("FAIL stream_stall got %0d expected 0", bus.stall_cnt); end
    endtask

    task automatic test_hazard();
        do_reset();
        bus.in_valid = 1; bus.instr = 16'h1040; cycle();   // writer of r1
        bus.instr = 16'h1400; cycle();                     // reader of r1
        bus.in_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            n_checks += 2;
            if (s_out_valid !== 1'b0) begin n_fails++; $display("FAIL hazard_out_valid k=%0d got %b expected 0", k, s_out_valid); end
            if (s_stall !== 8'(k - 1)) begin n_fails++; $display("FAIL hazard_stall k=%0d got %0d expected %0d", k, s_stall, k - 1); end
        end
        bus.wb_valid = 1; bus.wb_rd = 2'd1; cycle();
        n_checks++;
        if (s_out_valid !== 1'b0) begin n_fails++; $display("FAIL hazard_no_bypass got %b expected 0", s_out_valid); end
        bus.wb_valid = 0; cycle();
        n_checks += 2;
        if (s_out_valid !== 1'b1) begin n_fails++; $display("FAIL hazard_release got %b expected 1", s_out_valid); end
        if (s_stall !== 8'd5)     begin n_fails++; $display("FAIL hazard_stall_final got %0d expected 5", s_stall); end
    endtask

    task automatic test_wb_collide();
        do_reset();
        bus.in_valid = 1; bus.instr = 16'h1080; cycle();   // writer of r2
        bus.instr = 16'h1200;                              // reader of r2
        bus.wb_valid = 1; bus.wb_rd = 2'd2; cycle();       // issue + clear of r2 together
        bus.in_valid = 0; bus.wb_valid = 0;
        cycle(); cycle();
        n_checks += 2;
        if (s_out_valid !== 1'b0) begin n_fails++; $display("FAIL collide_stall got %b expected 0", s_out_valid); end
        if (s_stall !== 8'd1)     begin n_fails++; $display("FAIL collide_stall_cnt got %0d expected 1", s_stall); end
        bus.wb_valid = 1; bus.wb_rd = 2'd2; cycle();
        bus.wb_valid = 0; cycle();
        n_checks++;
        if (s_out_valid !== 1'b1) begin n_fails++; $display("FAIL collide_release got %b expected 1", s_out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        bus.in_valid = 1; bus.instr = 16'h1040; cycle();
        bus.instr = 16'h1400; cycle();
        bus.in_valid = 0; cycle();
        bus.flush = 1; bus.in_valid = 1; bus.instr = 16'h2000; cycle();
        n_checks += 2;
        if (s_in_ready !== 1'b0)  begin n_fails++; $display("FAIL flush_in_ready got %b expected 0", s_in_ready); end
        if (s_out_valid !== 1'b0) begin n_fails++; $display("FAIL flush_out_valid got %b expected 0", s_out_valid); end
        bus.flush = 0; bus.instr = 16'h1400; cycle();      // buffer empty again, reload reader of r1
        n_checks += 2;
        if (s_in_ready !== 1'b1)  begin n_fails++; $display("FAIL flush_empty_ready got %b expected 1", s_in_ready); end
        if (s_out_valid !== 1'b0) begin n_fails++; $display("FAIL flush_empty_valid got %b expected 0", s_out_valid); end
        bus.in_valid = 0; cycle();
        n_checks++;
        if (s_out_valid !== 1'b0) begin n_fails++; $display("FAIL flush_sb_kept got %b expected 0", s_out_valid); end
        bus.wb_valid = 1; bus.wb_rd = 2'd1; cycle();
        bus.wb_valid = 0; cycle();
        n_checks++;
        if (s_out_valid !== 1'b1) begin n_fails++; $display("FAIL flush_release got %b expected 1", s_out_valid); end
    endtask

    task automatic test_halt();
        do_reset();
        bus.in_valid = 1; bus.instr = 16'hF000; cycle();
        bus.instr = 16'h1000; cycle();
        for (int k = 0; k < 10; k++) begin
            bus.wb_valid = k[0]; bus.wb_rd = 2'(k);
            cycle();
            n_checks += 3;
            if (s_halted !== 1'b1)    begin n_fails++; $display("FAIL halt_halted k=%0d got %b expected 1", k, s_halted); end
            if (s_in_ready !== 1'b0)  begin n_fails++; $display("FAIL halt_in_ready k=%0d got %b expected 0", k, s_in_ready); end
            if (s_out_valid !== 1'b0) begin n_fails++; $display("FAIL halt_out_valid k=%0d got %b expected 0", k, s_out_valid); end
        end
        bus.wb_valid = 0;
        rst = 1; cycle();
        rst = 0; cycle();
        n_checks += 3;
        if (s_halted !== 1'b0)   begin n_fails++; $display("FAIL halt_reset_halted got %b expected 0", s_halted); end
        if (s_stall !== 8'd0)    begin n_fails++; $display("FAIL halt_reset_stall got %0d expected 0", s_stall); end
        if (s_in_ready !== 1'b1) begin n_fails++; $display("FAIL halt_reset_ready got %b expected 1", s_in_ready); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.in_valid = 1; bus.instr = 16'h3980; cycle();
        bus.instr = 16'h5000; bus.out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_checks += 4;
            if (s_out_valid !== 1'b1)   begin n_fails++; $display("FAIL bp_out_valid k=%0d got %b expected 1", k, s_out_valid); end
            if (s_in_ready !== 1'b0)    begin n_fails++; $display("FAIL bp_in_ready k=%0d got %b expected 0", k, s_in_ready); end
            if (s_fields !== 10'h0E6)   begin n_fails++; $display("FAIL bp_fields k=%0d got %h expected 0e6", k, s_fields); end
            if (s_stall !== 8'd0)       begin n_fails++; $display("FAIL bp_stall k=%0d got %0d expected 0", k, s_stall); end
        end
        bus.out_ready = 1; cycle();
        n_checks++;
        if (s_in_ready !== 1'b1) begin n_fails++; $display("FAIL bp_release got %b expected 1", s_in_ready); end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.in_valid = 1; bus.instr = 16'h1040; cycle();
        bus.instr = 16'h1400; cycle();
        bus.in_valid = 0;
        for (int k = 0; k < STALL_MAX + 20; k++) cycle();
        n_checks++;
        if (s_stall !== 8'(STALL_MAX)) begin n_fails++; $display("FAIL sat_stall got %0d expected %0d", s_stall, STALL_MAX); end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            ins = 16'($urandom);
            if (ins[15:12] == 4'hF) ins[15:12] = 4'h0;
            bus.in_valid  = ($urandom % 4) != 0;
            bus.instr     = ins;
            bus.out_ready = ($urandom % 4) != 0;
            bus.wb_valid  = ($urandom % 2) != 0;
            bus.wb_rd     = 2'($urandom);
            bus.flush     = ($urandom % 16) == 0;
            cycle();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        n_issued = 0;
        rst = 0;
        test_reset();
        test_stream();
        test_hazard();
        test_wb_collide();
        test_flush();
        test_halt();
        test_backpressure();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
